// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller:
// FSM states, ALU operation codes, mux select codes, opcode/funct values.
package mc_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_WB_R   = 4'd4,
        S_EXEC_I = 4'd5,
        S_WB_I   = 4'd6,
        S_MADDR  = 4'd7,
        S_MRD    = 4'd8,
        S_WB_M   = 4'd9,
        S_MWR    = 4'd10,
        S_BRANCH = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_AND = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_SLT = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_LUI = 3'b110;

    localparam logic [1:0] SB_B   = 2'b00;
    localparam logic [1:0] SB_4   = 2'b01;
    localparam logic [1:0] SB_IMM = 2'b10;
    localparam logic [1:0] SB_BR  = 2'b11;

    localparam logic [1:0] PS_ALU    = 2'b00;
    localparam logic [1:0] PS_ALUOUT = 2'b01;
    localparam logic [1:0] PS_JUMP   = 2'b10;

    localparam logic [5:0] OP_R     = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_SLT = 6'h2A;

endpackage

// File: rtl/mc_alu_dec.sv
// Opcode/funct decoder: ALU operation for R and I forms, immediate
// extension mode, and detection of unsupported instructions.
module mc_alu_dec
    import mc_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [2:0] r_op,
    output logic [2:0] i_op,
    output logic       i_ext,
    output logic       illegal
);

    logic bad_funct;

    always_comb begin
        r_op      = ALU_ADD;
        bad_funct = 1'b0;
        case (funct)
            FN_ADD:  r_op = ALU_ADD;
            FN_SUB:  r_op = ALU_SUB;
            FN_AND:  r_op = ALU_AND;
            FN_OR:   r_op = ALU_OR;
            FN_XOR:  r_op = ALU_XOR;
            FN_SLT:  r_op = ALU_SLT;
            default: bad_funct = 1'b1;
        endcase
    end

    always_comb begin
        i_op    = ALU_ADD;
        i_ext   = 1'b1;
        illegal = 1'b0;
        case (op)
            OP_R:     illegal = bad_funct;
            OP_ADDI,
            OP_ADDIU: begin
                i_op  = ALU_ADD;
                i_ext = 1'b1;
            end
            OP_ORI: begin
                i_op  = ALU_OR;
                i_ext = 1'b0;
            end
            OP_LUI: begin
                i_op  = ALU_LUI;
                i_ext = 1'b0;
            end
            OP_J, OP_BEQ, OP_LW, OP_SW: illegal = 1'b0;
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM with memory wait watchdog and sticky faults.
// Control outputs decode from the state register (plus mem_ready in fetch).
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [31:0] ir,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        MemtoReg,
    output logic        RegDst,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  AluOp,
    output logic        extOp,
    output logic [1:0]  PCSource,
    output logic [1:0]  fault,
    output logic [3:0]  state_o
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             mem_state;
    logic             expired;
    logic [5:0]       op;
    logic [2:0]       r_op;
    logic [2:0]       i_op;
    logic             i_ext;
    logic             illegal;
    logic             unused_bits;

    assign op          = ir[31:26];
    // zero is consumed by the datapath together with PCWriteCond
    assign unused_bits = ^{zero, ir[25:6]};

    mc_alu_dec u_dec (
        .op      (op),
        .funct   (ir[5:0]),
        .r_op    (r_op),
        .i_op    (i_op),
        .i_ext   (i_ext),
        .illegal (illegal)
    );

    assign mem_state = (state == S_FETCH) || (state == S_MRD) ||
                       (state == S_MWR);
    assign cnt_inc   = cnt + 1'b1;
    assign expired   = !mem_ready && (cnt_inc == CNT_W'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            fault <= 2'b00;
        end else begin
            // counter is zero whenever a memory state is entered
            if (mem_state && !mem_ready && !expired)
                cnt <= cnt_inc;
            else
                cnt <= '0;
            if (mem_state && expired) begin
                fault[1] <= 1'b1;
                state    <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE:
                        if (run) state <= S_FETCH;
                    S_FETCH:
                        if (mem_ready) state <= S_DECODE;
                    S_DECODE:
                        if (illegal) begin
                            fault[0] <= 1'b1;
                            state    <= S_FETCH;
                        end else begin
                            case (op)
                                OP_R:    state <= S_EXEC_R;
                                OP_LW,
                                OP_SW:   state <= S_MADDR;
                                OP_BEQ:  state <= S_BRANCH;
                                OP_J:    state <= S_JUMP;
                                default: state <= S_EXEC_I;
                            endcase
                        end
                    S_EXEC_R: state <= S_WB_R;
                    S_EXEC_I: state <= S_WB_I;
                    S_MADDR:
                        state <= (op == OP_LW) ? S_MRD : S_MWR;
                    S_MRD:
                        if (mem_ready) state <= S_WB_M;
                    S_MWR:
                        if (mem_ready) state <= S_FETCH;
                    S_WB_R, S_WB_I, S_WB_M,
                    S_BRANCH, S_JUMP:
                        state <= S_FETCH;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SB_B;
        AluOp       = ALU_ADD;
        extOp       = 1'b0;
        PCSource    = PS_ALU;
        case (state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SB_4;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB = SB_BR;
                extOp   = 1'b1;
            end
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                AluOp   = r_op;
            end
            S_WB_R: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SB_IMM;
                AluOp   = i_op;
                extOp   = i_ext;
            end
            S_WB_I: RegWrite = 1'b1;
            S_MADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SB_IMM;
                extOp   = 1'b1;
            end
            S_MRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_WB_M: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                AluOp       = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PS_ALUOUT;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PS_JUMP;
            end
            default: ;
        endcase
    end

    assign state_o = state;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: instruction sequences, memory stalls,
// watchdog boundary, illegal opcode and asynchronous reset.
module tb_mc_ctrl;
    import mc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [31:0] ir;
    logic        zero;
    logic        mem_ready;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic        MemtoReg, RegDst, RegWrite, ALUSrcA, extOp;
    logic [1:0]  ALUSrcB, PCSource, fault;
    logic [2:0]  AluOp;
    logic [3:0]  state_o;
    logic [17:0] ctl;

    int checks = 0;
    int errors = 0;

    logic [17:0] FET, FETW, DEC, XADD, XSUB, WBR, MAD, MRDC, WBM;
    logic [17:0] BRC, JMC, XORI, WBI, MWRC, C0;

    always #5 clk = ~clk;

    mc_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .ir          (ir),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .AluOp       (AluOp),
        .extOp       (extOp),
        .PCSource    (PCSource),
        .fault       (fault),
        .state_o     (state_o)
    );

    assign ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                  MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, AluOp,
                  extOp, PCSource};

    function automatic logic [17:0] mk(
        input logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa,
        input logic [1:0] sb, input logic [2:0] op,
        input logic ext, input logic [1:0] ps);
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa,
                sb, op, ext, ps};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic rdy, input logic [3:0] st,
                       input logic [17:0] c, input string tag);
        @(negedge clk);
        mem_ready = rdy;
        #1;
        chk({tag, "_state"}, 32'(state_o), 32'(st));
        chk({tag, "_ctl"}, 32'(ctl), 32'(c));
    endtask

    initial begin
        C0   = '0;
        FET  = mk(1,0,0,1,0,1,0,0,0,0,2'b01,3'b000,0,2'b00);
        FETW = mk(0,0,0,1,0,0,0,0,0,0,2'b01,3'b000,0,2'b00);
        DEC  = mk(0,0,0,0,0,0,0,0,0,0,2'b11,3'b000,1,2'b00);
        XADD = mk(0,0,0,0,0,0,0,0,0,1,2'b00,3'b000,0,2'b00);
        XSUB = mk(0,0,0,0,0,0,0,0,0,1,2'b00,3'b100,0,2'b00);
        WBR  = mk(0,0,0,0,0,0,0,1,1,0,2'b00,3'b000,0,2'b00);
        MAD  = mk(0,0,0,0,0,0,0,0,0,1,2'b10,3'b000,1,2'b00);
        MRDC = mk(0,0,1,1,0,0,0,0,0,0,2'b00,3'b000,0,2'b00);
        WBM  = mk(0,0,0,0,0,0,1,0,1,0,2'b00,3'b000,0,2'b00);
        BRC  = mk(0,1,0,0,0,0,0,0,0,1,2'b00,3'b100,0,2'b01);
        JMC  = mk(1,0,0,0,0,0,0,0,0,0,2'b00,3'b000,0,2'b10);
        XORI = mk(0,0,0,0,0,0,0,0,0,1,2'b10,3'b010,0,2'b00);
        WBI  = mk(0,0,0,0,0,0,0,0,1,0,2'b00,3'b000,0,2'b00);
        MWRC = mk(0,0,1,0,1,0,0,0,0,0,2'b00,3'b000,0,2'b00);

        rst_n = 1'b0; run = 1'b0; ir = '0; zero = 1'b0; mem_ready = 1'b0;
        #1;
        chk("rst_state", 32'(state_o), 32'(S_IDLE));
        chk("rst_ctl", 32'(ctl), 32'(C0));
        chk("rst_fault", 32'(fault), 32'd0);

        @(negedge clk);
        rst_n = 1'b1; run = 1'b1; ir = 32'h00221820;
        #1;
        chk("idle_run_state", 32'(state_o), 32'(S_IDLE));
        chk("idle_run_ctl", 32'(ctl), 32'(C0));

        cyc(1, S_FETCH,  FET,  "add_f");
        cyc(1, S_DECODE, DEC,  "add_d");
        cyc(1, S_EXEC_R, XADD, "add_x");
        cyc(1, S_WB_R,   WBR,  "add_w");

        ir = 32'h00221822;
        cyc(1, S_FETCH,  FET,  "sub_f");
        cyc(1, S_DECODE, DEC,  "sub_d");
        cyc(1, S_EXEC_R, XSUB, "sub_x");
        cyc(1, S_WB_R,   WBR,  "sub_w");

        ir = 32'h8C220004;
        cyc(1, S_FETCH,  FET,  "lw_f");
        cyc(1, S_DECODE, DEC,  "lw_d");
        cyc(1, S_MADDR,  MAD,  "lw_a");
        for (int i = 0; i < 3; i++) cyc(0, S_MRD, MRDC, "lw_stall");
        cyc(1, S_MRD,    MRDC, "lw_rd");
        cyc(1, S_WB_M,   WBM,  "lw_w");

        ir = 32'h10220003;
        cyc(0, S_FETCH,  FETW, "beq_fwait");
        cyc(1, S_FETCH,  FET,  "beq_f");
        cyc(1, S_DECODE, DEC,  "beq_d");
        cyc(1, S_BRANCH, BRC,  "beq_b");

        ir = 32'h08000010;
        cyc(1, S_FETCH,  FET,  "j_f");
        cyc(1, S_DECODE, DEC,  "j_d");
        cyc(1, S_JUMP,   JMC,  "j_j");

        ir = 32'h34220005;
        cyc(1, S_FETCH,  FET,  "ori_f");
        cyc(1, S_DECODE, DEC,  "ori_d");
        cyc(1, S_EXEC_I, XORI, "ori_x");
        cyc(1, S_WB_I,   WBI,  "ori_w");
        chk("fault_clean", 32'(fault), 32'd0);

        ir = 32'hFC000000;
        cyc(1, S_FETCH,  FET,  "ill_f");
        cyc(1, S_DECODE, DEC,  "ill_d");
        cyc(1, S_FETCH,  FET,  "ill_next");
        chk("ill_fault", 32'(fault), 32'd1);

        #1 rst_n = 1'b0;
        #1;
        chk("arst_fetch_state", 32'(state_o), 32'(S_IDLE));
        chk("arst_fetch_fault", 32'(fault), 32'd0);

        @(negedge clk);
        rst_n = 1'b1; ir = 32'hAC220008;
        cyc(1, S_FETCH,  FET,  "sw1_f");
        cyc(1, S_DECODE, DEC,  "sw1_d");
        cyc(1, S_MADDR,  MAD,  "sw1_a");
        for (int i = 0; i < 15; i++) cyc(0, S_MWR, MWRC, "sw1_wait");
        cyc(1, S_MWR,    MWRC, "sw1_last_ready");
        cyc(1, S_FETCH,  FET,  "sw1_back");
        chk("sw1_fault", 32'(fault), 32'd0);

        cyc(1, S_DECODE, DEC,  "sw2_d");
        cyc(1, S_MADDR,  MAD,  "sw2_a");
        for (int i = 0; i < 16; i++) cyc(0, S_MWR, MWRC, "sw2_wait");
        cyc(0, S_IDLE,   C0,   "sw2_timeout");
        chk("sw2_fault", 32'(fault), 32'd2);

        cyc(1, S_FETCH,  FET,  "sw3_f");
        cyc(1, S_DECODE, DEC,  "sw3_d");
        cyc(1, S_MADDR,  MAD,  "sw3_a");
        cyc(0, S_MWR,    MWRC, "sw3_w");
        #2 rst_n = 1'b0;
        #1;
        chk("arst_mwr_state", 32'(state_o), 32'(S_IDLE));
        chk("arst_mwr_ctl", 32'(ctl), 32'(C0));
        chk("arst_mwr_fault", 32'(fault), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("restart_idle", 32'(state_o), 32'(S_IDLE));
        cyc(1, S_FETCH,  FET,  "restart_f");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
